// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a DEPTH-word FIFO feeds a start/data/parity/stop serialiser; start bit leaves 1 cycle after a write to an idle block.
// No backpressure: a write while full is dropped and flagged on o_ovf for one cycle.

module fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_rdy,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push;
   logic             pop;

   // Full is judged on the current count, so a write racing a pop while full is still dropped.
   assign full   = (count == CNT_FULL);
   assign empty  = (count == '0);
   assign push   = wr_vld && !full;
   assign pop    = rd_rdy && !empty;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem[wr_ptr] <= wr_dat;
   end
endmodule

module uart_tx_fifo #(
   parameter int DIV       = 234,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [DATA_BITS-1:0] i_data,
   input  logic                 i_we,
   output logic                 o_data,
   output logic                 o_busy,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_ovf
);
   localparam int DW = $clog2(DIV);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE   = DW'(1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [DW-1:0]        div_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS:0]   shreg;
   logic [DATA_BITS-1:0] head;
   logic                 pop;
   logic                 shift;
   logic                 bit_inc;
   logic                 tick;
   logic                 par_bit;

   fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .wr_vld (i_we),
      .wr_dat (i_data),
      .rd_rdy (pop),
      .rd_dat (head),
      .full   (o_full),
      .empty  (o_empty)
   );

   assign tick    = (div_cnt == DIV_LAST);
   assign par_bit = (PARITY == 1) ? ~^head : ^head;
   assign o_busy  = (state != IDLE);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      shift     = 1'b0;
      bit_inc   = 1'b0;
      o_data    = 1'b1;
      case (state)
         IDLE: begin
            if (!o_empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            o_data = 1'b0;
            if (tick) state_nxt = DATA;
         end
         DATA: begin
            o_data = shreg[0];
            if (tick) begin
               shift = 1'b1;
               if (bit_cnt == DATA_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
               else                      bit_inc   = 1'b1;
            end
         end
         PAR: begin
            // After DATA_BITS shifts the latched parity bit sits at the LSB.
            o_data = shreg[0];
            if (tick) state_nxt = STOP;
         end
         STOP: begin
            if (tick) begin
               if (bit_cnt != STOP_LAST) begin
                  bit_inc = 1'b1;
               end else if (!o_empty) begin
                  pop       = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '1;
         o_ovf   <= 1'b0;
      end else begin
         o_ovf <= i_we && o_full;
         if (state_nxt != state || state == IDLE) begin
            div_cnt <= '0;
            bit_cnt <= '0;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_ONE;
            if (bit_inc) bit_cnt <= bit_cnt + BIT_ONE;
         end
         if (pop)        shreg <= {par_bit, head};
         else if (shift) shreg <= {1'b1, shreg[DATA_BITS:1]};
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four parameter sets, directed frame checks plus random traffic against a queue-based line model.
module tb_uart_tx_fifo;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] din;
   logic [3:0] we;
   logic [3:0] rst_n;
   wire  [3:0] txd, busy, full, empty, ovf;

   uart_tx_fifo u0 (
      .i_clk(clk), .i_rst_n(rst_n[0]), .i_data(din), .i_we(we[0]),
      .o_data(txd[0]), .o_busy(busy[0]), .o_full(full[0]), .o_empty(empty[0]), .o_ovf(ovf[0]));
   uart_tx_fifo #(.DIV(4), .PARITY(2), .STOP_BITS(2)) u1 (
      .i_clk(clk), .i_rst_n(rst_n[1]), .i_data(din), .i_we(we[1]),
      .o_data(txd[1]), .o_busy(busy[1]), .o_full(full[1]), .o_empty(empty[1]), .o_ovf(ovf[1]));
   uart_tx_fifo #(.DIV(4), .PARITY(1), .DATA_BITS(5)) u2 (
      .i_clk(clk), .i_rst_n(rst_n[2]), .i_data(din[4:0]), .i_we(we[2]),
      .o_data(txd[2]), .o_busy(busy[2]), .o_full(full[2]), .o_empty(empty[2]), .o_ovf(ovf[2]));
   uart_tx_fifo #(.DIV(4), .DEPTH(4)) u3 (
      .i_clk(clk), .i_rst_n(rst_n[3]), .i_data(din), .i_we(we[3]),
      .o_data(txd[3]), .o_busy(busy[3]), .o_full(full[3]), .o_empty(empty[3]), .o_ovf(ovf[3]));

   int cfg_div   [4] = '{234, 4, 4, 4};
   int cfg_db    [4] = '{8, 8, 5, 8};
   int cfg_par   [4] = '{0, 2, 1, 0};
   int cfg_sb    [4] = '{1, 2, 1, 1};
   int cfg_depth [4] = '{4, 4, 4, 4};

   int errors = 0;
   int checks = 0;
   int act = 0;
   int busy_cnt = 0;
   int ovf_cnt = 0;
   int n, run, nb;
   logic prev;
   logic [11:0] got;

   // Model: line_q holds the expected TX level for every remaining cycle of queued frames.
   bit line_q[$];
   int fq[$];
   bit m_ovf;

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @%0t observed=%b expected=%b", tag, $time, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @%0t observed=%0d expected=%0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step(input logic w, input logic r, input logic [7:0] d);
      bit full_pre;
      int wd;
      int ones;
      bit fr[$];
      if (r !== 1'b1) begin
         line_q.delete();
         fq.delete();
         m_ovf = 1'b0;
      end else begin
         full_pre = (fq.size() == cfg_depth[act]);
         if (line_q.size() > 0) line_q.delete(0);
         if (line_q.size() == 0 && fq.size() > 0) begin
            wd = fq.pop_front();
            ones = 0;
            fr.push_back(1'b0);
            for (int i = 0; i < cfg_db[act]; i++) begin
               fr.push_back(((wd >> i) & 1) == 1);
               ones += (wd >> i) & 1;
            end
            if (cfg_par[act] == 2) fr.push_back((ones % 2) == 1);
            else if (cfg_par[act] == 1) fr.push_back((ones % 2) == 0);
            for (int i = 0; i < cfg_sb[act]; i++) fr.push_back(1'b1);
            foreach (fr[j])
               for (int c = 0; c < cfg_div[act]; c++) line_q.push_back(fr[j]);
         end
         m_ovf = (w === 1'b1) && full_pre;
         if (w === 1'b1 && !full_pre) fq.push_back(int'(d) & ((1 << cfg_db[act]) - 1));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step(we[act], rst_n[act], din);
      #1;
      chk_bit("line",  txd[act],   line_q.size() > 0 ? line_q[0] : 1'b1);
      chk_bit("busy",  busy[act],  line_q.size() > 0);
      chk_bit("empty", empty[act], fq.size() == 0);
      chk_bit("full",  full[act],  fq.size() == cfg_depth[act]);
      chk_bit("ovf",   ovf[act],   m_ovf);
      if (busy[act] === 1'b1) busy_cnt++;
      if (ovf[act] === 1'b1) ovf_cnt++;
   endtask

   task automatic write(input logic [7:0] d);
      din = d;
      we[act] = 1'b1;
      cyc();
      we[act] = 1'b0;
   endtask

   task automatic start(input int a);
      we = '0;
      act = a;
      rst_n[a] = 1'b0;
      cyc();
      rst_n[a] = 1'b1;
      busy_cnt = 0;
      ovf_cnt = 0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy[act] === 1'b1 && k < budget) begin
         cyc();
         k++;
      end
      chk_bit("wait_idle_in_budget", k < budget, 1'b1);
   endtask

   task automatic grab(input int nbits, output logic [11:0] g);
      g = '0;
      for (int i = 0; i < 200; i++) begin
         cyc();
         if (busy[act] !== 1'b1) break;
         if (i % 4 == 1 && i / 4 < nbits) g[nbits - 1 - i / 4] = txd[act];
      end
   endtask

   initial begin
      din = '0;
      we = '0;
      rst_n = '0;
      act = 0;
      cyc();
      rst_n = '1;

      // Default parameters, one 0x55 frame.
      start(0);
      chk_bit("rst_data",  txd[0],   1'b1);
      chk_bit("rst_busy",  busy[0],  1'b0);
      chk_bit("rst_empty", empty[0], 1'b1);
      chk_bit("rst_full",  full[0],  1'b0);
      chk_bit("rst_ovf",   ovf[0],   1'b0);
      write(8'h55);
      chk_bit("t0_empty_at_k", empty[0], 1'b0);
      chk_bit("t0_busy_at_k",  busy[0],  1'b0);
      cyc();
      chk_bit("t0_start_k1",  txd[0],   1'b0);
      chk_bit("t0_popped_k1", empty[0], 1'b1);
      run = 1;
      nb = 0;
      for (int i = 0; i < 3000 && busy[0] === 1'b1; i++) begin
         prev = txd[0];
         cyc();
         if (txd[0] !== prev || busy[0] !== 1'b1) begin
            chk_int("t0_bit_len", run, 234);
            run = 1;
            nb++;
         end else begin
            run++;
         end
      end
      chk_int("t0_bits", nb, 10);
      chk_int("t0_busy_cycles", busy_cnt, 2340);

      // Even parity, two stop bits.
      start(1);
      write(8'h07);
      grab(12, got);
      chk_int("t1_frame", int'(got), 'h707);
      chk_bit("t1_parity", got[2], 1'b1);
      chk_int("t1_len", busy_cnt, 48);

      // Odd parity, 5 data bits.
      start(2);
      write(8'h1F);
      grab(8, got);
      chk_int("t2_frame", int'(got), 'h7D);
      chk_int("t2_len", busy_cnt, 32);

      // Overflow: six writes into a 4-deep FIFO.
      start(3);
      for (int i = 1; i <= 6; i++) begin
         write(8'(i));
         if (i == 4) chk_bit("t3_not_full_3", full[3], 1'b0);
         if (i == 5) chk_bit("t3_full_4", full[3], 1'b1);
      end
      chk_bit("t3_ovf_pulse", ovf[3], 1'b1);
      cyc();
      chk_bit("t3_ovf_clear", ovf[3], 1'b0);
      wait_idle(400);
      chk_int("t3_busy_contig", busy_cnt, 200);
      chk_int("t3_ovf_count", ovf_cnt, 1);
      chk_bit("t3_end_empty", empty[3], 1'b1);

      // Reset in the middle of data bit 3, with a write offered during reset.
      start(3);
      write(8'hA5);
      repeat (18) cyc();
      rst_n[3] = 1'b0;
      we[3] = 1'b1;
      din = 8'h3C;
      cyc();
      chk_bit("t4_rst_data",  txd[3],   1'b1);
      chk_bit("t4_rst_busy",  busy[3],  1'b0);
      chk_bit("t4_rst_empty", empty[3], 1'b1);
      rst_n[3] = 1'b1;
      we[3] = 1'b0;
      busy_cnt = 0;
      repeat (60) cyc();
      chk_int("t4_no_frame", busy_cnt, 0);

      // Write coinciding with the pop at a frame boundary, one entry queued.
      start(3);
      write(8'h3A);
      cyc();
      write(8'hC5);
      repeat (38) cyc();
      write(8'h96);
      chk_bit("t5_no_gap", txd[3],   1'b0);
      chk_bit("t5_empty",  empty[3], 1'b0);
      chk_bit("t5_full",   full[3],  1'b0);
      write(8'h11);
      write(8'h22);
      chk_bit("t5_count3_not_full", full[3], 1'b0);
      write(8'h33);
      chk_bit("t5_count4_full", full[3], 1'b1);
      wait_idle(400);
      chk_int("t5_busy_total", busy_cnt, 240);

      // Random traffic with occasional resets on the DIV=4 instances.
      for (int a = 1; a <= 3; a++) begin
         start(a);
         repeat (1500) begin
            din = 8'($urandom);
            we[act] = ($urandom_range(0, 7) == 0);
            rst_n[act] = ($urandom_range(0, 599) != 0);
            cyc();
         end
         we = '0;
         rst_n[act] = 1'b1;
         wait_idle(400);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with a built-in transmit FIFO, successor to the team's fixed 8N1 single-byte transmitter. It serialises words LSB-first at a configurable bit period, with configurable data width, parity and stop bits. Back-to-back frames go out with no idle gap while the FIFO holds data. It sits between the on-chip producer (command/debug logic) and the board TX pin.

## Interface

Parameters:
- DIV, 234: clock cycles per bit (round(f_clk / baud)); legal range ≥ 2; counter width $clog2(DIV).
- DATA_BITS, 8: payload bits per frame; legal range 5–8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- DEPTH, 4: FIFO entries; power of two ≥ 2.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_data  in  DATA_BITS  word to transmit.
- i_we  in  1  write strobe; 1-cycle pulse per word.
- o_data  out  1  serial TX line; idle high.
- o_busy  out  1  high while a frame is being shifted out.
- o_full  out  1  FIFO holds DEPTH entries.
- o_empty  out  1  FIFO holds 0 entries.
- o_ovf  out  1  1-cycle pulse when a write is dropped because the FIFO is full.

## Operation

- FIFO: circular buffer with wrap-around read/write pointers and a count of width $clog2(DEPTH)+1.
  - A write is accepted when i_we=1 and o_full=0.
  - A write with o_full=1 is dropped; FIFO contents are unchanged and o_ovf pulses.
  - o_full is evaluated on the current count, so a write in the same cycle as a pop while full is still dropped.
- Frame format: start bit (0), DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
  - Parity bit: even = XOR of the data bits; odd = inverted XOR.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: o_data=1. If the FIFO is non-empty, pop the head, latch the word and computed parity into the shift register, and go to START.
  - START → DATA after DIV cycles.
  - DATA: shift each DIV cycles. After DATA_BITS bits, go to PAR if PARITY≠0, else to STOP.
  - PAR → STOP after DIV cycles.
  - STOP: lasts STOP_BITS×DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Bit counter and divider counter reset to 0 on each state entry. The divider counts 0..DIV-1.
- o_busy = (state ≠ IDLE).
- Reset (i_rst_n=0 at a rising edge): FIFO emptied, pointers and count = 0, state = IDLE.
  - Output values after reset: o_data=1, o_busy=0, o_empty=1, o_full=0, o_ovf=0.
  - Reset mid-frame aborts the frame; the line returns high on the reset edge.
  - i_we is ignored while i_rst_n=0.

## Timing

- A write accepted at edge k is visible at k: o_empty falls and the count increments.
- FSM idle with FIFO empty before the write: the pop and START entry occur at edge k+1, and o_data falls at k+1. Write-to-start-bit latency is 1 cycle.
- Each bit occupies exactly DIV cycles.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles, from the o_data falling edge to the end of the last stop bit.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle.
- A pop and a write in the same cycle (not full): the count is unchanged, and both pointers advance.
- o_busy rises on the START-entry edge. It falls on the edge leaving STOP for IDLE.
- o_ovf is high for exactly the cycle after the dropped write edge.
- o_empty and o_full update on the same edge as the count.

## Test plan

- Default parameters, write 0x55 once.
  - Expected: o_data low at k+1.
  - Bits 1,0,1,0,1,0,1,0 each last 234 cycles, then a stop bit.
  - o_busy high for 2340 cycles.
- DIV=4, PARITY=2, STOP_BITS=2, write 0x07.
  - Expected: frame 0,1,1,1,0,0,0,0,0,1,1,1, each bit 4 cycles.
  - The parity bit is 1.
  - 48 cycles total.
- DIV=4, PARITY=1, DATA_BITS=5, write 0x1F.
  - Expected: start, then five 1s, parity 0, stop.
  - 32 cycles.
- DIV=4, DEPTH=4, write 0x01,0x02,0x03,0x04,0x05,0x06 on consecutive cycles.
  - Expected: 0x01 is popped on the next edge, leaving 4 entries, so o_full=1.
  - Writes 0x02–0x05 are accepted. 0x06 is dropped, with o_ovf pulsing once.
  - Five frames go out back-to-back with no idle gap, then o_empty=1 and o_busy=0.
- DIV=4, write 0xA5, then assert i_rst_n=0 for 1 cycle mid-data-bit 3.
  - Expected: o_data=1 and o_busy=0 at the reset edge.
  - The FIFO is empty, and no further frame follows.
- Simultaneous i_we and pop at a frame boundary with 1 entry queued.
  - Expected: the count stays at 1.
  - Both words are transmitted in order.
